hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REGW, default 5, register-address width.
REQ-002 Parameter DIV_LAT, default 32, divider busy cycles (>=1).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rsD, rtD  in  REGW each  decode-stage source registers.
REQ-006 branchD  in  1  branch in decode.
REQ-007 rsE, rtE, writeregE  in  REGW each  execute sources/destination.
REQ-008 regwriteE, memtoregE, div_startE  in  1 each  execute writes GPR / is load / is div.
REQ-009 writeregM, writeregW  in  REGW each  memory/writeback destinations.
REQ-010 regwriteM, memtoregM, regwriteW  in  1 each  write/load qualifiers.
REQ-011 exceptM  in  1  exception taken in memory stage.
REQ-012 imem_stall, dmem_stall  in  1 each  instruction/data SRAM not ready.
REQ-013 stallF, stallD, stallE, stallM  out  1 each  hold stage register.
REQ-014 flushD, flushE, flushM, flushW  out  1 each  load bubble into stage register.
REQ-015 forwardaE, forwardbE  out  2 each  00 regfile, 01 from M, 10 from W.
REQ-016 div_done  out  1  one-cycle divider-result-valid pulse.
REQ-017 perf_stall_cnt  out  32  stallF cycle count.

Function
REQ-018 forwardaE SHALL be 01 if rsE!=0, rsE==writeregM, regwriteM; else 10 if rsE!=0, rsE==writeregW, regwriteW; else 00; forwardbE identical on rtE.
REQ-019 lwstall SHALL be memtoregE && rtE!=0 && (rtE==rsD || rtE==rtD).
REQ-020 brstall SHALL be branchD && ((regwriteE && writeregE!=0 && writeregE in {rsD,rtD}) || (memtoregM && writeregM!=0 && writeregM in {rsD,rtD})).
REQ-021 Divider FSM states IDLE, BUSY, DONE; IDLE->BUSY when div_startE && !exceptM && !dmem_stall, loading cnt=DIV_LAT-1; BUSY decrements cnt each non-dmem_stall cycle, ->DONE at cnt==0; DONE->IDLE unconditionally; no start accepted in DONE.
REQ-022 divstall SHALL be (IDLE && div_startE) || BUSY; a div with no other stall therefore stalls exactly DIV_LAT+1 cycles; div_done=1 only in DONE.
REQ-023 Priority, first match wins: exceptM -> flushD/E/M/W=1, all stalls 0, FSM->IDLE next cycle; dmem_stall -> stallF/D/E/M=1, flushW=1; divstall -> stallF/D/E=1, flushM=1; lwstall||brstall -> stallF/D=1, flushE=1; imem_stall -> stallF=1, flushD=1; else all 0.
REQ-024 A stage SHALL never see stall and flush together; every flush/stall output combinational from inputs and FSM state, zero-cycle latency.

Reset
REQ-025 While rst=1: all stalls 0, flushD/E/M/W=1, div_done 0, forwards 00.
REQ-026 Next edge after rst: FSM IDLE, cnt 0, perf_stall_cnt 0; reset mid-divide aborts it with no div_done.

Configuration
REQ-027 Macro HAZARD_PERF_EN defined: perf_stall_cnt increments each non-reset cycle with stallF=1, saturating at 32'hFFFF_FFFF.
REQ-028 Macro undefined: port present, tied 0, no counter flops.

Structure
REQ-029 Package hazard_pkg holds FSM state enum and forward-select constants FWD_RF=00, FWD_M=01, FWD_W=10.
REQ-030 Sub-module div_tracker holds FSM and counter, outputs divstall and div_done; priority logic stays in hazard_ctrl.

Verification
REQ-031 Load $2 in E, decode rsD=2 -> stallF/D=1, flushE=1 one cycle; next cycle forwardaE=10.
REQ-032 DIV_LAT=4, div_startE held -> stallE=1 five cycles, flushM=1 same cycles, div_done=1 on sixth.
REQ-033 exceptM during BUSY cnt=2 -> flushD/E/M/W=1, stalls 0, FSM IDLE next cycle, no div_done.
REQ-034 dmem_stall with lwstall and imem_stall -> stallF/D/E/M=1, flushW=1, flushE=0, flushD=0.
REQ-035 rsE=0, writeregM=0, regwriteM=1 -> forwardaE=00; rsE=3 matching M and W -> 01.
REQ-036 HAZARD_PERF_EN, ten stallF cycles after reset -> perf_stall_cnt=10; rst pulse -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: divider FSM states and forwarding-select codes shared by the hazard unit
package hazard_pkg;
  typedef enum logic [1:0] {DIV_IDLE = 2'b00, DIV_BUSY = 2'b01, DIV_DONE = 2'b10} div_state_e;
  localparam logic [1:0] ST_IDLE = DIV_IDLE;
  localparam logic [1:0] ST_BUSY = DIV_BUSY;
  localparam logic [1:0] ST_DONE = DIV_DONE;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M = 2'b01;
  localparam logic [1:0] FWD_W = 2'b10;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-to-hazard-unit bundle; master is the pipeline, slave the hazard unit
interface hazard_ctrl_if #(parameter int REGW = 5);
  logic [REGW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, regwriteE, memtoregE, div_startE, regwriteM, memtoregM, regwriteW;
  logic exceptM, imem_stall, dmem_stall;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, div_done;
  logic [1:0] forwardaE, forwardbE;
  logic [31:0] perf_stall_cnt;
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW, branchD, regwriteE, memtoregE,
           div_startE, regwriteM, memtoregM, regwriteW, exceptM, imem_stall, dmem_stall,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, div_done,
           forwardaE, forwardbE, perf_stall_cnt
  );
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW, branchD, regwriteE, memtoregE,
           div_startE, regwriteM, memtoregM, regwriteW, exceptM, imem_stall, dmem_stall,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, div_done,
           forwardaE, forwardbE, perf_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_div_tracker.sv
// div_tracker: multi-cycle divider occupancy FSM producing divstall and the div_done pulse
module div_tracker import hazard_pkg::*; #(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_start,
  input  logic exc,
  input  logic dstall,
  output logic divstall,
  output logic div_done
);
  localparam int CW = $clog2(DIV_LAT + 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || exc) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (div_start && !dstall) begin
        state <= ST_BUSY;
        cnt <= CW'(DIV_LAT - 1);
      end
    end else if (state == ST_BUSY) begin
      if (!dstall) begin
        if (cnt == '0) state <= ST_DONE;
        else cnt <= cnt - CW'(1);
      end
    end else begin
      state <= ST_IDLE;
    end
  end
  assign divstall = (state == ST_IDLE && div_start) || state == ST_BUSY;
  assign div_done = state == ST_DONE;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control; HAZARD_PERF_EN enables the stallF cycle counter
module hazard_ctrl import hazard_pkg::*; #(
  parameter int REGW = 5,
  parameter int DIV_LAT = 32
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave hz
);
  logic divstall, div_done_i, lwstall, brstall;
  logic [7:0] ctl;
  function automatic logic [1:0] fwd(input logic [REGW-1:0] src, input logic [REGW-1:0] wm,
                                     input logic rwm, input logic [REGW-1:0] ww, input logic rww);
    return (src != '0 && src == wm && rwm) ? FWD_M : (src != '0 && src == ww && rww) ? FWD_W : FWD_RF;
  endfunction
  div_tracker #(.DIV_LAT(DIV_LAT)) u_div (
    .clk(clk), .rst(rst), .div_start(hz.div_startE), .exc(hz.exceptM), .dstall(hz.dmem_stall),
    .divstall(divstall), .div_done(div_done_i)
  );
  assign lwstall = hz.memtoregE && hz.rtE != '0 && (hz.rtE == hz.rsD || hz.rtE == hz.rtD);
  assign brstall = hz.branchD &&
    ((hz.regwriteE && hz.writeregE != '0 && (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD)) ||
     (hz.memtoregM && hz.writeregM != '0 && (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD)));
  // {stallF,stallD,stallE,stallM, flushD,flushE,flushM,flushW}; first match wins
  assign ctl = rst                  ? 8'b0000_1111 :
               hz.exceptM           ? 8'b0000_1111 :
               hz.dmem_stall        ? 8'b1111_0001 :
               divstall             ? 8'b1110_0010 :
               (lwstall || brstall) ? 8'b1100_0100 :
               hz.imem_stall        ? 8'b1000_1000 : 8'b0000_0000;
  assign {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE, hz.flushM, hz.flushW} = ctl;
  assign hz.forwardaE = rst ? FWD_RF : fwd(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
  assign hz.forwardbE = rst ? FWD_RF : fwd(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
  assign hz.div_done = !rst && div_done_i;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else if (ctl[7] && perf_q != '1) perf_q <= perf_q + 32'd1;
  end
  assign hz.perf_stall_cnt = perf_q;
`else
  assign hz.perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;
  localparam int REGW = 5;
  localparam int DIV_LAT = 4;
  logic clk = 1'b1;
  logic rst;
  int total = 0;
  int bad = 0;
  int div_rem = 0;
  bit div_pend = 0;
  longint perf_m = 0;
  bit perf_known = 0;
  logic [12:0] obs, exp_v;
  logic [31:0] perf_obs;
  hazard_ctrl_if #(.REGW(REGW)) hif();
  hazard_ctrl #(.REGW(REGW), .DIV_LAT(DIV_LAT)) dut (.clk(clk), .rst(rst), .hz(hif));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, o, e);
    end
  endtask

  function automatic logic [1:0] mfwd(input int src);
    if (src != 0 && src == int'(hif.writeregM) && hif.regwriteM) return 2'b01;
    if (src != 0 && src == int'(hif.writeregW) && hif.regwriteW) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit hits(input int r, input bit q);
    return q && r != 0 && (r == int'(hif.rsD) || r == int'(hif.rtD));
  endfunction

  function automatic logic [12:0] model();
    logic sf, sd, se, sm, fd, fe, fm, fw;
    bit divs, lw, br;
    divs = div_rem > 0 || (!div_pend && hif.div_startE);
    lw = hits(int'(hif.rtE), hif.memtoregE);
    br = hif.branchD && (hits(int'(hif.writeregE), hif.regwriteE) || hits(int'(hif.writeregM), hif.memtoregM));
    {sf, sd, se, sm, fd, fe, fm, fw} = '0;
    if (rst || hif.exceptM) {fd, fe, fm, fw} = 4'hF;
    else if (hif.dmem_stall) {sf, sd, se, sm, fw} = 5'h1F;
    else if (divs) {sf, sd, se, fm} = 4'hF;
    else if (lw || br) {sf, sd, fe} = 3'h7;
    else if (hif.imem_stall) {sf, fd} = 2'h3;
    return {sf, sd, se, sm, fd, fe, fm, fw, rst ? 2'b00 : mfwd(int'(hif.rsE)),
            rst ? 2'b00 : mfwd(int'(hif.rtE)), !rst && div_pend};
  endfunction

  function automatic logic [31:0] perf_exp();
`ifdef HAZARD_PERF_EN
    return 32'(perf_m);
`else
    return 32'd0;
`endif
  endfunction

  task automatic cycle();
    @(negedge clk);
    exp_v = model();
    obs = {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.flushD, hif.flushE, hif.flushM,
           hif.flushW, hif.forwardaE, hif.forwardbE, hif.div_done};
    perf_obs = hif.perf_stall_cnt;
    chk("ctl", 32'(obs), 32'(exp_v));
    if (perf_known) chk("perf", perf_obs, perf_exp());
    @(posedge clk);
    if (rst) begin
      div_rem = 0;
      div_pend = 0;
      perf_m = 0;
      perf_known = 1;
    end else begin
      if (exp_v[12] && perf_m < 64'hFFFF_FFFF) perf_m++;
      if (hif.exceptM) begin
        div_rem = 0;
        div_pend = 0;
      end else if (div_pend) div_pend = 0;
      else if (div_rem > 0) begin
        if (!hif.dmem_stall) begin
          div_rem--;
          div_pend = div_rem == 0;
        end
      end else if (hif.div_startE && !hif.dmem_stall) div_rem = DIV_LAT;
    end
    #1;
  endtask

  task automatic clr();
    {hif.rsD, hif.rtD, hif.rsE, hif.rtE, hif.writeregE, hif.writeregM, hif.writeregW} = '0;
    {hif.branchD, hif.regwriteE, hif.memtoregE, hif.div_startE, hif.regwriteM, hif.memtoregM} = '0;
    {hif.regwriteW, hif.exceptM, hif.imem_stall, hif.dmem_stall} = '0;
  endtask

  task automatic rnd();
    hif.rsD = REGW'($urandom_range(0, 3));
    hif.rtD = REGW'($urandom_range(0, 3));
    hif.rsE = REGW'($urandom_range(0, 3));
    hif.rtE = REGW'($urandom_range(0, 3));
    hif.writeregE = REGW'($urandom_range(0, 3));
    hif.writeregM = REGW'($urandom_range(0, 3));
    hif.writeregW = REGW'($urandom_range(0, 3));
    {hif.branchD, hif.regwriteE, hif.memtoregE, hif.regwriteM, hif.memtoregM, hif.regwriteW} = 6'($urandom);
    hif.div_startE = $urandom_range(0, 3) == 0;
    hif.exceptM = $urandom_range(0, 15) == 0;
    hif.dmem_stall = $urandom_range(0, 7) == 0;
    hif.imem_stall = $urandom_range(0, 3) == 0;
  endtask

  initial begin
    int ns, nf, done_at, any_done;
    rst = 1'b1;
    clr();
    #1;
    cycle();
    chk("rst_ctl", 32'(obs[12:1]), 32'h00F << 4);
    rst = 1'b0;
    cycle();
    hif.memtoregE = 1'b1;
    hif.rtE = 5'd2;
    hif.rsD = 5'd2;
    cycle();
    chk("lw_stall", 32'(obs[12:5]), 32'b1100_0100);
    clr();
    hif.rsE = 5'd2;
    hif.writeregW = 5'd2;
    hif.regwriteW = 1'b1;
    cycle();
    chk("lw_fwd_w", 32'(obs[4:3]), 32'b10);
    clr();
    hif.div_startE = 1'b1;
    ns = 0;
    nf = 0;
    done_at = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      ns += int'(obs[10]);
      nf += int'(obs[6]);
      if (obs[0]) begin
        done_at = i;
        break;
      end
    end
    chk("div_stallE_cycles", 32'(ns), 32'd5);
    chk("div_flushM_cycles", 32'(nf), 32'd5);
    chk("div_done_cycle", 32'(done_at), 32'd5);
    clr();
    cycle();
    hif.div_startE = 1'b1;
    cycle();
    cycle();
    hif.exceptM = 1'b1;
    cycle();
    chk("exc_busy", 32'(obs[12:5]), 32'b0000_1111);
    clr();
    any_done = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      any_done |= int'(obs[0]) | int'(obs[10]);
    end
    chk("exc_abort", 32'(any_done), 32'd0);
    hif.dmem_stall = 1'b1;
    hif.imem_stall = 1'b1;
    hif.memtoregE = 1'b1;
    hif.rtE = 5'd1;
    hif.rtD = 5'd1;
    cycle();
    chk("dmem_prio", 32'(obs[12:5]), 32'b1111_0001);
    clr();
    hif.regwriteM = 1'b1;
    cycle();
    chk("fwd_r0", 32'(obs[4:3]), 32'b00);
    hif.rsE = 5'd3;
    hif.rtE = 5'd3;
    hif.writeregM = 5'd3;
    hif.writeregW = 5'd3;
    hif.regwriteW = 1'b1;
    cycle();
    chk("fwd_m_prio", 32'(obs[4:1]), 32'b0101);
    clr();
    hif.branchD = 1'b1;
    hif.regwriteE = 1'b1;
    hif.writeregE = 5'd4;
    hif.rtD = 5'd4;
    cycle();
    chk("br_stall", 32'(obs[12:5]), 32'b1100_0100);
    clr();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    hif.imem_stall = 1'b1;
    repeat (10) cycle();
    clr();
    cycle();
`ifdef HAZARD_PERF_EN
    chk("perf_ten", perf_obs, 32'd10);
`else
    chk("perf_ten", perf_obs, 32'd0);
`endif
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("perf_rst", perf_obs, 32'd0);
    for (int i = 0; i < 600; i++) begin
      rnd();
      rst = $urandom_range(0, 49) == 0;
      cycle();
    end
    rst = 1'b0;
    clr();
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
